// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Moore-style sequencer for a multi-cycle RV32I datapath. It steps each
//   instruction through IF/ID/EX/MEM/WB and drives the datapath write enables
//   and mux selects. Memory accesses wait on mem_ready, so latency can vary.
//   An optional wait limit sends the controller to a terminal FAULT state.
//
//   Optional feature macro: ECALL_HALT_EN
//     defined   : ECALL with halt_cond = 1 enters a terminal HALT state and
//                 sets is_halted. ECALL with halt_cond = 0 acts as a NOP.
//     undefined : ECALL is always a NOP, is_halted is tied to 0, and
//                 halt_cond is ignored.
//
//   Ports
//     clk, reset      clock, synchronous active-high reset
//     opcode          IR[6:0], valid from ID onward
//     mem_ready       memory finishes the current access this cycle
//     halt_cond       x17 == 10 flag (used only with ECALL_HALT_EN)
//     pc_write        PC load pulse, asserted once per instruction
//     ir_write        IR load
//     mem_read        memory read request
//     mem_write       memory write request
//     i_or_d          memory address select (0 = PC, 1 = ALUOut)
//     reg_write       register file write
//     mem_to_reg      writeback select MDR
//     pc_to_reg       writeback select PC+4
//     alu_src         ALU B select (0 = rs2, 1 = imm)
//     alu_op          00 add, 01 branch compare, 10 funct decode
//     branch          PC mux qualifier (taken iff bcond)
//     is_jal          PC mux qualifier
//     is_jalr         PC mux qualifier
//     is_halted       sticky halt
//     mem_timeout     sticky memory-wait fault
module multicycle_control_fsm #(
  parameter int MEM_WAIT_LIMIT = 0,
  parameter int WAIT_CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       halt_cond,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       branch,
  output logic       is_jal,
  output logic       is_jalr,
  output logic       is_halted,
  output logic       mem_timeout
);

  localparam logic [2:0] S_IF    = 3'd0;
  localparam logic [2:0] S_ID    = 3'd1;
  localparam logic [2:0] S_EX    = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_WAIT_LIMIT);

  logic [2:0]            state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  mem_wait;

`ifdef ECALL_HALT_EN
  logic halted_q, halted_d;
`else
  logic unused_halt_cond;
  assign unused_halt_cond = halt_cond;
`endif

  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    pc_to_reg   = 1'b0;
    alu_src     = 1'b0;
    alu_op      = ALU_ADD;
    branch      = 1'b0;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    is_halted   = 1'b0;
    mem_timeout = timeout_q;
    state_d     = state_q;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q;
`ifdef ECALL_HALT_EN
    halted_d    = halted_q;
    is_halted   = halted_q;
`endif

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        if (mem_ready) state_d = S_ID;
      end
      S_ID: begin
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR:
            state_d = S_EX;
          OP_ECALL: begin
`ifdef ECALL_HALT_EN
            if (halt_cond) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              pc_write = 1'b1;
              state_d  = S_IF;
            end
`else
            pc_write = 1'b1;
            state_d  = S_IF;
`endif
          end
          // unknown opcodes retire as a NOP
          default: begin
            pc_write = 1'b1;
            state_d  = S_IF;
          end
        endcase
      end
      S_EX: begin
        case (opcode)
          OP_R: begin
            alu_op  = ALU_FN;
            state_d = S_WB;
          end
          OP_I: begin
            alu_op  = ALU_FN;
            alu_src = 1'b1;
            state_d = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          OP_BRANCH: begin
            // PC mux chooses target vs PC+4 from bcond
            alu_op   = ALU_BR;
            branch   = 1'b1;
            pc_write = 1'b1;
            state_d  = S_IF;
          end
          OP_JAL, OP_JALR: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (opcode == OP_LOAD) begin
          mem_read = 1'b1;
          if (mem_ready) state_d = S_WB;
        end else if (opcode == OP_STORE) begin
          mem_write = 1'b1;
          pc_write  = mem_ready;
          if (mem_ready) state_d = S_IF;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
        is_jal     = (opcode == OP_JAL);
        is_jalr    = (opcode == OP_JALR);
        pc_to_reg  = (opcode == OP_JAL) || (opcode == OP_JALR);
        state_d    = S_IF;
      end
      S_HALT, S_FAULT: state_d = state_q;
      default: state_d = S_IF;
    endcase

    // wait counter runs only across consecutive stalled IF/MEM cycles
    mem_wait = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready;
    if (mem_wait) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
      if ((MEM_WAIT_LIMIT != 0) && (wait_cnt_q == WAIT_LIMIT)) begin
        state_d    = S_FAULT;
        timeout_d  = 1'b1;
        wait_cnt_d = wait_cnt_q;
      end
    end

    // a reset cycle drives nothing, so an abandoned instruction writes nothing
    if (reset) begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      i_or_d      = 1'b0;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      pc_to_reg   = 1'b0;
      alu_src     = 1'b0;
      alu_op      = ALU_ADD;
      branch      = 1'b0;
      is_jal      = 1'b0;
      is_jalr     = 1'b0;
      is_halted   = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IF;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef ECALL_HALT_EN
  always_ff @(posedge clk) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a per-cycle vector table of
// {reset, opcode, mem_ready, halt_cond, expected outputs}, plus per-opcode
// cycle-count sequences. The DUT runs with MEM_WAIT_LIMIT = 4.
module tb_multicycle_control_fsm;

  localparam logic [6:0] ADD = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ECALL = 7'b1110011;
  localparam logic [6:0] NOPOP = 7'b0000000;

  // output vector bit masks
  localparam logic [15:0] PCW  = 16'h8000;
  localparam logic [15:0] IRW  = 16'h4000;
  localparam logic [15:0] MRD  = 16'h2000;
  localparam logic [15:0] MWR  = 16'h1000;
  localparam logic [15:0] IORD = 16'h0800;
  localparam logic [15:0] REGW = 16'h0400;
  localparam logic [15:0] M2R  = 16'h0200;
  localparam logic [15:0] P2R  = 16'h0100;
  localparam logic [15:0] ASRC = 16'h0080;
  localparam logic [15:0] AOPF = 16'h0040;
  localparam logic [15:0] AOPB = 16'h0020;
  localparam logic [15:0] BR   = 16'h0010;
  localparam logic [15:0] JALB = 16'h0008;
  localparam logic [15:0] JALRB = 16'h0004;
  localparam logic [15:0] HLT  = 16'h0002;
  localparam logic [15:0] TMO  = 16'h0001;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic        hc;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = ADD;
  logic mem_ready = 1'b1;
  logic halt_cond = 1'b0;
  logic pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write;
  logic mem_to_reg, pc_to_reg, alu_src, branch, is_jal, is_jalr;
  logic is_halted, mem_timeout;
  logic [1:0] alu_op;
  logic [15:0] obs;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_WAIT_LIMIT(4), .WAIT_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .halt_cond(halt_cond), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
    .alu_src(alu_src), .alu_op(alu_op), .branch(branch), .is_jal(is_jal),
    .is_jalr(is_jalr), .is_halted(is_halted), .mem_timeout(mem_timeout)
  );

  assign obs = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
                mem_to_reg, pc_to_reg, alu_src, alu_op, branch, is_jal,
                is_jalr, is_halted, mem_timeout};

  task automatic add(input logic r, input logic [6:0] op, input logic rdy,
                     input logic hc, input logic [15:0] e);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.hc = hc; v.exp = e;
    tbl.push_back(v);
  endtask

  // reset one cycle, run op with mem_ready = 1, count cycles up to pc_write
  task automatic run_instr(input logic [6:0] op, input int want, input string nm);
    int cyc;
    bit seen;
    @(negedge clk);
    reset = 1'b1; opcode = op; mem_ready = 1'b1; halt_cond = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      cyc++;
      if (pc_write) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen || cyc != want) begin
      errors++;
      $display("FAIL cycles_%s: got %0d (pc_write seen %0d) want %0d", nm, cyc, seen, want);
    end
    @(negedge clk);
    #1;
    checks++;
    if (!(mem_read && ir_write && !i_or_d && !pc_write)) begin
      errors++;
      $display("FAIL back_to_if_%s: got %h want %h", nm, obs, MRD | IRW);
    end
  endtask

  initial begin
    // reset 3 cycles, then add
    repeat (3) add(1, ADD, 1, 0, 16'h0);
    add(0, ADD, 1, 0, MRD | IRW);
    add(0, ADD, 1, 0, 16'h0);
    add(0, ADD, 1, 0, AOPF);
    add(0, ADD, 1, 0, REGW | PCW);
    // lw: 2 IF waits, 3 MEM waits -> 10 cycles
    add(0, LW, 0, 0, MRD);
    add(0, LW, 0, 0, MRD);
    add(0, LW, 1, 0, MRD | IRW);
    add(0, LW, 1, 0, 16'h0);
    add(0, LW, 1, 0, ASRC);
    repeat (3) add(0, LW, 0, 0, MRD | IORD);
    add(0, LW, 1, 0, MRD | IORD);
    add(0, LW, 1, 0, REGW | PCW | M2R);
    // beq
    add(0, BEQ, 1, 0, MRD | IRW);
    add(0, BEQ, 1, 0, 16'h0);
    add(0, BEQ, 1, 0, AOPB | BR | PCW);
    // jalr
    add(0, JALR, 1, 0, MRD | IRW);
    add(0, JALR, 1, 0, 16'h0);
    add(0, JALR, 1, 0, ASRC);
    add(0, JALR, 1, 0, REGW | PCW | P2R | JALRB);
    // jal
    add(0, JAL, 1, 0, MRD | IRW);
    add(0, JAL, 1, 0, 16'h0);
    add(0, JAL, 1, 0, ASRC);
    add(0, JAL, 1, 0, REGW | PCW | P2R | JALB);
    // addi
    add(0, ADDI, 1, 0, MRD | IRW);
    add(0, ADDI, 1, 0, 16'h0);
    add(0, ADDI, 1, 0, ASRC | AOPF);
    add(0, ADDI, 1, 0, REGW | PCW);
    // sw, ready immediately
    add(0, SW, 1, 0, MRD | IRW);
    add(0, SW, 1, 0, 16'h0);
    add(0, SW, 1, 0, ASRC);
    add(0, SW, 1, 0, MWR | IORD | PCW);
    // unknown opcode and ecall (halt_cond 0) retire as NOP
    add(0, NOPOP, 1, 0, MRD | IRW);
    add(0, NOPOP, 1, 0, PCW);
    add(0, ECALL, 1, 0, MRD | IRW);
    add(0, ECALL, 1, 0, PCW);
    // reset in the middle of lw MEM
    add(0, LW, 1, 0, MRD | IRW);
    add(0, LW, 1, 0, 16'h0);
    add(0, LW, 1, 0, ASRC);
    add(0, LW, 0, 0, MRD | IORD);
    add(1, LW, 0, 0, 16'h0);
    add(0, LW, 0, 0, MRD);
    add(0, LW, 1, 0, MRD | IRW);
    // ecall with halt_cond = 1
`ifdef ECALL_HALT_EN
    add(0, ECALL, 1, 1, 16'h0);
    add(0, ECALL, 1, 1, HLT);
    add(0, ADD, 1, 0, HLT);
`else
    add(0, ECALL, 1, 1, PCW);
    add(0, ECALL, 1, 1, MRD | IRW);
    add(0, ECALL, 1, 1, PCW);
`endif
    add(1, ADD, 1, 0, 16'h0);
    // sw with memory never ready: 5 MEM cycles (count 0..4) then FAULT
    add(0, SW, 1, 0, MRD | IRW);
    add(0, SW, 1, 0, 16'h0);
    add(0, SW, 1, 0, ASRC);
    repeat (5) add(0, SW, 0, 0, MWR | IORD);
    add(0, SW, 0, 0, TMO);
    add(0, SW, 1, 0, TMO);
    add(0, ADD, 1, 0, TMO);
    add(1, ADD, 1, 0, 16'h0);
    add(0, ADD, 1, 0, MRD | IRW);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      opcode = tbl[i].op;
      mem_ready = tbl[i].rdy;
      halt_cond = tbl[i].hc;
      #1;
      checks++;
      if (obs !== tbl[i].exp) begin
        errors++;
        $display("FAIL row_%0d: got %h want %h", i, obs, tbl[i].exp);
      end
    end

    run_instr(ADD, 4, "add");
    run_instr(JAL, 4, "jal");
    run_instr(LW, 5, "lw");
    run_instr(SW, 4, "sw");
    run_instr(BEQ, 3, "beq");
    run_instr(ECALL, 2, "ecall");
    run_instr(NOPOP, 2, "nop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
